// File: rtl/id_stage.sv
// RV32I instruction decode stage: field extraction, immediate generation, 32x32 register
// file with optional writeback forwarding, and a single-entry valid/ready output register.
module id_stage #(
    parameter bit BYPASS = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] instr,
    input  logic [31:0] pc_in,
    input  logic        if_valid,
    output logic        if_ready,
    input  logic        flush,
    input  logic        ex_ready,
    input  logic        wb_we,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,
    output logic        id_valid,
    output logic [31:0] id_pc,
    output logic [6:0]  id_opcode,
    output logic [4:0]  id_rd,
    output logic [4:0]  id_rs1,
    output logic [4:0]  id_rs2,
    output logic [2:0]  id_funct3,
    output logic [6:0]  id_funct7,
    output logic [31:0] id_imm,
    output logic [31:0] id_rs1_data,
    output logic [31:0] id_rs2_data,
    output logic        id_illegal
);

    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_FENCE  = 7'h0F;
    localparam logic [6:0] OP_IMM    = 7'h13;
    localparam logic [6:0] OP_AUIPC  = 7'h17;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_REG    = 7'h33;
    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_JALR   = 7'h67;
    localparam logic [6:0] OP_JAL    = 7'h6F;
    localparam logic [6:0] OP_SYSTEM = 7'h73;

    logic [31:0] regs [32];
    logic        accept;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic        illegal;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;

    // Handshake: a transfer happens on a rising edge when valid and ready are both high;
    // decode is ready whenever its output slot is empty or being drained by execute.
    assign if_ready = ex_ready | ~id_valid;
    assign accept   = if_valid & if_ready & ~flush;

    assign rs1 = instr[19:15];
    assign rs2 = instr[24:20];

    always_comb begin
        imm     = '0;
        illegal = 1'b0;
        case (instr[6:0])
            OP_LOAD, OP_IMM, OP_JALR, OP_SYSTEM:
                imm = {{20{instr[31]}}, instr[31:20]};
            OP_STORE:
                imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            OP_BRANCH:
                imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            OP_LUI, OP_AUIPC:
                imm = {instr[31:12], 12'b0};
            OP_JAL:
                imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            OP_REG, OP_FENCE:
                imm = '0;
            default:
                illegal = 1'b1;
        endcase
    end

    // Forwarding covers the same-edge writeback so the operand is never one write stale.
    assign rs1_val = (rs1 == 5'd0) ? '0 :
                     (BYPASS && wb_we && (wb_rd == rs1)) ? wb_data : regs[rs1];
    assign rs2_val = (rs2 == 5'd0) ? '0 :
                     (BYPASS && wb_we && (wb_rd == rs2)) ? wb_data : regs[rs2];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_we && (wb_rd != 5'd0)) begin
            regs[wb_rd] <= wb_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            id_valid    <= 1'b0;
            id_pc       <= '0;
            id_opcode   <= '0;
            id_rd       <= '0;
            id_rs1      <= '0;
            id_rs2      <= '0;
            id_funct3   <= '0;
            id_funct7   <= '0;
            id_imm      <= '0;
            id_rs1_data <= '0;
            id_rs2_data <= '0;
            id_illegal  <= 1'b0;
        end else if (flush) begin
            id_valid <= 1'b0;
        end else if (accept) begin
            id_valid    <= 1'b1;
            id_pc       <= pc_in;
            id_opcode   <= instr[6:0];
            id_rd       <= instr[11:7];
            id_rs1      <= rs1;
            id_rs2      <= rs2;
            id_funct3   <= instr[14:12];
            id_funct7   <= instr[31:25];
            id_imm      <= imm;
            id_rs1_data <= rs1_val;
            id_rs2_data <= rs2_val;
            id_illegal  <= illegal;
        end else if (ex_ready) begin
            id_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: a table of decode vectors with hand-computed fields,
// followed by stall/flush, drain and asynchronous-reset sequences.
module tb_id_stage;

    logic        clk;
    logic        reset_n;
    logic [31:0] instr;
    logic [31:0] pc_in;
    logic        if_valid;
    logic        if_ready;
    logic        flush;
    logic        ex_ready;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [6:0]  id_opcode;
    logic [4:0]  id_rd;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic [2:0]  id_funct3;
    logic [6:0]  id_funct7;
    logic [31:0] id_imm;
    logic [31:0] id_rs1_data;
    logic [31:0] id_rs2_data;
    logic        id_illegal;

    id_stage #(.BYPASS(1'b1)) dut (
        .clk(clk), .reset_n(reset_n), .instr(instr), .pc_in(pc_in),
        .if_valid(if_valid), .if_ready(if_ready), .flush(flush), .ex_ready(ex_ready),
        .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .id_valid(id_valid), .id_pc(id_pc), .id_opcode(id_opcode), .id_rd(id_rd),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_funct3(id_funct3), .id_funct7(id_funct7),
        .id_imm(id_imm), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
        .id_illegal(id_illegal)
    );

    // Clock/reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        wb_we;
        logic [4:0]  wb_rd;
        logic [31:0] wb_data;
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [31:0] imm;
        logic        illegal;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
    } vec_t;

    localparam int NV = 14;
    vec_t vec [NV];
    logic [31:0] exp_q [$];
    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [31:0] i_instr, input logic [31:0] i_pc,
                         input logic i_we, input logic [4:0] i_rd, input logic [31:0] i_data);
        instr   = i_instr;
        pc_in   = i_pc;
        wb_we   = i_we;
        wb_rd   = i_rd;
        wb_data = i_data;
    endtask

    initial begin
        // instr, pc, we, wrd, wdata | opcode, rd, rs1, rs2, f3, f7, imm, ill, rs1_data, rs2_data
        vec[0]  = '{32'h00108093, 32'h04, 1'b0, 5'd0, 32'h0,
                    7'h13, 5'd1, 5'd1, 5'd1, 3'd0, 7'h00, 32'h1, 1'b0, 32'h0, 32'h0};
        vec[1]  = '{32'h00108093, 32'h08, 1'b1, 5'd2, 32'hDEADBEEF,
                    7'h13, 5'd1, 5'd1, 5'd1, 3'd0, 7'h00, 32'h1, 1'b0, 32'h0, 32'h0};
        vec[2]  = '{32'h00210113, 32'h0C, 1'b0, 5'd0, 32'h0,
                    7'h13, 5'd2, 5'd2, 5'd2, 3'd0, 7'h00, 32'h2, 1'b0, 32'hDEADBEEF, 32'hDEADBEEF};
        vec[3]  = '{32'h00108093, 32'h10, 1'b1, 5'd1, 32'h55,
                    7'h13, 5'd1, 5'd1, 5'd1, 3'd0, 7'h00, 32'h1, 1'b0, 32'h55, 32'h55};
        vec[4]  = '{32'h00000013, 32'h14, 1'b1, 5'd0, 32'hFFFFFFFF,
                    7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'h0, 1'b0, 32'h0, 32'h0};
        vec[5]  = '{32'h00000013, 32'h18, 1'b0, 5'd0, 32'h0,
                    7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'h0, 1'b0, 32'h0, 32'h0};
        // beq x0,x0,-4: imm[11] comes from instr[7]=1, so the offset is -4
        vec[6]  = '{32'hFE000EE3, 32'h1C, 1'b0, 5'd0, 32'h0,
                    7'h63, 5'd29, 5'd0, 5'd0, 3'd0, 7'h7F, 32'hFFFFFFFC, 1'b0, 32'h0, 32'h0};
        vec[7]  = '{32'h123450B7, 32'h20, 1'b0, 5'd0, 32'h0,
                    7'h37, 5'd1, 5'd8, 5'd3, 3'd5, 7'h09, 32'h12345000, 1'b0, 32'h0, 32'h0};
        vec[8]  = '{32'hFFDFF06F, 32'h24, 1'b0, 5'd0, 32'h0,
                    7'h6F, 5'd0, 5'd31, 5'd29, 3'd7, 7'h7F, 32'hFFFFFFFC, 1'b0, 32'h0, 32'h0};
        vec[9]  = '{32'h0020A423, 32'h28, 1'b0, 5'd0, 32'h0,
                    7'h23, 5'd8, 5'd1, 5'd2, 3'd2, 7'h00, 32'h8, 1'b0, 32'h55, 32'hDEADBEEF};
        vec[10] = '{32'hFFFFFFFF, 32'h2C, 1'b0, 5'd0, 32'h0,
                    7'h7F, 5'd31, 5'd31, 5'd31, 3'd7, 7'h7F, 32'h0, 1'b1, 32'h0, 32'h0};
        vec[11] = '{32'h002081B3, 32'h30, 1'b0, 5'd0, 32'h0,
                    7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h00, 32'h0, 1'b0, 32'h55, 32'hDEADBEEF};
        vec[12] = '{32'hFFF00293, 32'h34, 1'b0, 5'd0, 32'h0,
                    7'h13, 5'd5, 5'd0, 5'd31, 3'd0, 7'h7F, 32'hFFFFFFFF, 1'b0, 32'h0, 32'h0};
        vec[13] = '{32'h00001517, 32'h38, 1'b0, 5'd0, 32'h0,
                    7'h17, 5'd10, 5'd0, 5'd0, 3'd1, 7'h00, 32'h1000, 1'b0, 32'h0, 32'h0};

        reset_n  = 1'b0;
        flush    = 1'b0;
        ex_ready = 1'b1;
        if_valid = 1'b0;
        drive(32'h0, 32'h0, 1'b0, 5'd0, 32'h0);
        repeat (2) @(negedge clk);
        check("reset_id_valid", {31'b0, id_valid}, 32'h0);
        check("reset_if_ready", {31'b0, if_ready}, 32'h1);
        check("reset_id_pc", id_pc, 32'h0);
        check("reset_id_imm", id_imm, 32'h0);
        reset_n = 1'b1;

        // Table-driven decode vectors, one accept per cycle
        if_valid = 1'b1;
        for (int i = 0; i < NV; i++) begin
            drive(vec[i].instr, vec[i].pc, vec[i].wb_we, vec[i].wb_rd, vec[i].wb_data);
            exp_q.push_back(vec[i].pc);
            @(negedge clk);
            check($sformatf("v%0d_valid", i), {31'b0, id_valid}, 32'h1);
            check($sformatf("v%0d_pc", i), id_pc, exp_q.pop_front());
            check($sformatf("v%0d_opcode", i), {25'b0, id_opcode}, {25'b0, vec[i].opcode});
            check($sformatf("v%0d_rd", i), {27'b0, id_rd}, {27'b0, vec[i].rd});
            check($sformatf("v%0d_rs1", i), {27'b0, id_rs1}, {27'b0, vec[i].rs1});
            check($sformatf("v%0d_rs2", i), {27'b0, id_rs2}, {27'b0, vec[i].rs2});
            check($sformatf("v%0d_funct3", i), {29'b0, id_funct3}, {29'b0, vec[i].funct3});
            check($sformatf("v%0d_funct7", i), {25'b0, id_funct7}, {25'b0, vec[i].funct7});
            check($sformatf("v%0d_imm", i), id_imm, vec[i].imm);
            check($sformatf("v%0d_illegal", i), {31'b0, id_illegal}, {31'b0, vec[i].illegal});
            check($sformatf("v%0d_rs1_data", i), id_rs1_data, vec[i].rs1_data);
            check($sformatf("v%0d_rs2_data", i), id_rs2_data, vec[i].rs2_data);
        end

        // Stall for three cycles, then flush
        drive(32'h00108093, 32'h40, 1'b0, 5'd0, 32'h0);
        @(negedge clk);
        check("stall_setup_pc", id_pc, 32'h40);
        ex_ready = 1'b0;
        drive(32'hFFFFFFFF, 32'h44, 1'b0, 5'd0, 32'h0);
        #1;
        check("stall_if_ready", {31'b0, if_ready}, 32'h0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check($sformatf("stall%0d_valid", c), {31'b0, id_valid}, 32'h1);
            check($sformatf("stall%0d_pc", c), id_pc, 32'h40);
            check($sformatf("stall%0d_imm", c), id_imm, 32'h1);
            check($sformatf("stall%0d_if_ready", c), {31'b0, if_ready}, 32'h0);
        end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_valid", {31'b0, id_valid}, 32'h0);
        check("flush_if_ready", {31'b0, if_ready}, 32'h1);

        // Flush wins over a simultaneous accept
        ex_ready = 1'b1;
        flush    = 1'b1;
        drive(32'h00108093, 32'h48, 1'b0, 5'd0, 32'h0);
        @(negedge clk);
        flush = 1'b0;
        check("flush_accept_valid", {31'b0, id_valid}, 32'h0);

        // Accept then drain with no new input
        @(negedge clk);
        check("drain_setup_valid", {31'b0, id_valid}, 32'h1);
        check("drain_setup_pc", id_pc, 32'h48);
        if_valid = 1'b0;
        @(negedge clk);
        check("drain_valid", {31'b0, id_valid}, 32'h0);

        // Asynchronous reset in the middle of a cycle
        if_valid = 1'b1;
        drive(32'h00210113, 32'h80, 1'b0, 5'd0, 32'h0);
        @(negedge clk);
        check("prereset_valid", {31'b0, id_valid}, 32'h1);
        check("prereset_rs1_data", id_rs1_data, 32'hDEADBEEF);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_reset_valid", {31'b0, id_valid}, 32'h0);
        check("async_reset_pc", id_pc, 32'h0);
        check("async_reset_imm", id_imm, 32'h0);
        check("async_reset_opcode", {25'b0, id_opcode}, 32'h0);
        check("async_reset_rs1_data", id_rs1_data, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        drive(32'h00210113, 32'h84, 1'b0, 5'd0, 32'h0);
        @(negedge clk);
        check("postreset_valid", {31'b0, id_valid}, 32'h1);
        check("postreset_pc", id_pc, 32'h84);
        check("postreset_x2", id_rs1_data, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
